pc_int_unit: RTL and testbench
==============================

// Module: pc_int_unit
// PURPOSE
//  Parametrised program-counter unit with vectored interrupts and a nested
//  return-address stack. It owns the PC register, PC increment, branch
//  selection, interrupt entry and RETI return.
//  It sits between the control unit, branch comparator/ALU and the instruction
//  memory of the single-cycle RISC core.
// PARAMETERS
//  N        32            PC / address width
//  RESET_PC 0             PC value loaded on reset
//  INT_VEC  'h100         interrupt service routine entry address
//  PC_STEP  4             increment applied for sequential fetch
//  DEPTH    4             return-stack entries (max interrupt nesting), >=1
// PORTS
//  clk      in   1             rising-edge clock
//  rst      in   1             synchronous, active-high reset
//  updPC    in   1             instruction boundary; PC advances this cycle
//  isBranch in   1             take brTarget instead of NPC (qualified by updPC)
//  brTarget in   N             branch/jump target from ALU
//  isRet    in   1             RETI executing (qualified by updPC)
//  setIE    in   1             set interrupt enable (qualified by updPC)
//  clrIE    in   1             clear interrupt enable (qualified by updPC)
//  INT      in   1             level interrupt request, held by source until acked
//  PC       out  N             current fetch address
//  NPC      out  N             PC + PC_STEP, combinational
//  intAck   out  1             one-cycle pulse, cycle after interrupt accepted
//  IE       out  1             interrupt enable flag
//  stkDepth out  clog2(DEPTH+1) entries on return stack
//  stkErr   out  1             sticky: RETI on empty stack
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): PC=RESET_PC, IE=0, stack empty (stkDepth=0),
//    intAck=0, stkErr=0, state=RUN. rst mid-ISR discards all stack contents.
//  - NPC = PC + PC_STEP, modulo 2^N (wraps silently). nextSeq = isBranch ? brTarget : NPC.
//  - FSM states RUN, FAULT.
//  - RUN, updPC=0: PC, IE and stack hold. INT is ignored (not latched).
//  - RUN, updPC=1, priority high->low:
//    1. isRet & empty:      PC<=NPC, stkErr<=1, state<=FAULT.
//    2. isRet:              PC<=pop, IE<=1, depth-1.
//                           INT is not accepted this cycle, even if IE was 1.
//    3. INT & IE & !full:   push nextSeq, PC<=INT_VEC, IE<=0, depth+1,
//                           intAck<=1 the following cycle.
//                           Any setIE/clrIE in this cycle is overridden (IE<=0).
//    4. otherwise:          PC<=nextSeq. IE updates from setIE/clrIE; clrIE wins if both.
//  - INT & IE with stack full: not accepted. Instruction retires normally and INT
//    stays pending (level). Never overflows.
//  - Nesting: the ISR re-enables IE via setIE to allow a higher interrupt, up to DEPTH.
//  - FAULT: PC, IE and stack frozen. Inputs ignored. intAck=0. Exits only on rst.
//  - intAck is registered and high exactly 1 cycle per accepted interrupt.
//  - Latency: every update is visible on PC the cycle after the updPC edge.
//  - The stack is LIFO. Push and pop never occur in the same cycle (priority 2 over 3).
// STRUCTURE
//  - Package risc_pkg: state enum {RUN, FAULT}, default N, RESET_PC, INT_VEC,
//    PC_STEP constants, shared with the control unit.
//  - Sub-module ret_stack #(N, DEPTH):
//    - ports clk, rst, push, pop, din, top, full, empty, depth.
//    - registered array plus pointer.
//  - Top keeps the PC register, IE flag, FSM and next-PC priority mux.
// TESTING
//  1. rst=1 two cycles, then updPC=1 x3, no branch
//     -> PC 0,4,8,12. NPC=PC+4. IE=0. stkDepth=0.
//  2. PC=0x20, isBranch=1, brTarget=0x80, updPC=1
//     -> PC=0x80 next cycle.
//     Same with updPC=0 -> PC stays 0x20.
//  3. IE=1, PC=0x40, INT=1, updPC=1
//     -> PC=0x100, IE=0, stkDepth=1, intAck=1 for one cycle.
//     Later isRet+updPC -> PC=0x44, IE=1, stkDepth=0.
//  4. Branch to 0x200 coincident with accepted INT
//     -> stack holds 0x200. PC=0x100. RETI returns to 0x200.
//  5. DEPTH=2, ISR does setIE, nested INT twice
//     -> depth reaches 2. Third INT is held pending with no intAck and no corruption.
//     After one RETI the pending INT is accepted.
//  6. isRet on empty stack
//     -> stkErr=1, state FAULT, PC frozen despite updPC/INT.
//     rst -> PC=0, stkErr=0.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared core definitions: PC-unit FSM states and default address-map constants
// used by the PC unit and the control unit.
package risc_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } pc_state_e;

   localparam int          DEF_N        = 32;
   localparam int unsigned DEF_RESET_PC = 32'h0000_0000;
   localparam int unsigned DEF_INT_VEC  = 32'h0000_0100;
   localparam int unsigned DEF_PC_STEP  = 32'd4;

endpackage

// File: rtl/ret_stack.sv
// LIFO of interrupt return addresses; the top entry is readable combinationally
// so RETI can load it into the PC in the same cycle it is popped.
module ret_stack #(
   parameter int N     = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [N-1:0]               din,
   output logic [N-1:0]               top,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] depth
);

   localparam int DW = $clog2(DEPTH + 1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [N-1:0]  mem_q [DEPTH];
   logic [DW-1:0] cnt_q;
   logic [DW-1:0] cnt_d;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] top_idx;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (cnt_q == DW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign depth   = cnt_q;
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign wr_idx  = AW'(cnt_q);
   assign top_idx = AW'(cnt_q - DW'(1));
   assign top     = empty ? '0 : mem_q[top_idx];

   always_comb begin
      cnt_d = cnt_q;
      if (push_ok) begin
         cnt_d = cnt_q + DW'(1);
      end else if (pop_ok) begin
         cnt_d = cnt_q - DW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Entry contents need no reset: only slots below cnt_q are ever read.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_idx] <= din;
      end
   end

endmodule

// File: rtl/pc_int_unit.sv
// Program-counter unit: PC register, sequential/branch selection, vectored
// interrupt entry with nested return stack, RETI return and empty-stack fault.
module pc_int_unit
   import risc_pkg::*;
#(
   parameter int           N        = DEF_N,
   parameter logic [N-1:0] RESET_PC = N'(DEF_RESET_PC),
   parameter logic [N-1:0] INT_VEC  = N'(DEF_INT_VEC),
   parameter logic [N-1:0] PC_STEP  = N'(DEF_PC_STEP),
   parameter int           DEPTH    = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       updPC,
   input  logic                       isBranch,
   input  logic [N-1:0]               brTarget,
   input  logic                       isRet,
   input  logic                       setIE,
   input  logic                       clrIE,
   input  logic                       INT,
   output logic [N-1:0]               PC,
   output logic [N-1:0]               NPC,
   output logic                       intAck,
   output logic                       IE,
   output logic [$clog2(DEPTH+1)-1:0] stkDepth,
   output logic                       stkErr
);

   pc_state_e    state_q, state_d;
   logic [N-1:0] pc_q, pc_d;
   logic         ie_q, ie_d;
   logic         ack_q, ack_d;
   logic         err_q, err_d;

   logic [N-1:0] next_seq;
   logic [N-1:0] stk_top;
   logic         stk_full;
   logic         stk_empty;
   logic         stk_push;
   logic         stk_pop;

   assign NPC      = pc_q + PC_STEP;
   assign next_seq = isBranch ? brTarget : NPC;

   ret_stack #(
      .N     (N),
      .DEPTH (DEPTH)
   ) u_ret_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (stk_push),
      .pop   (stk_pop),
      .din   (next_seq),
      .top   (stk_top),
      .full  (stk_full),
      .empty (stk_empty),
      .depth (stkDepth)
   );

   // RETI outranks interrupt entry, so push and pop are mutually exclusive.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ie_d     = ie_q;
      ack_d    = 1'b0;
      err_d    = err_q;
      stk_push = 1'b0;
      stk_pop  = 1'b0;
      if (state_q == RUN && updPC) begin
         if (isRet && stk_empty) begin
            pc_d    = NPC;
            err_d   = 1'b1;
            state_d = FAULT;
         end else if (isRet) begin
            pc_d    = stk_top;
            ie_d    = 1'b1;
            stk_pop = 1'b1;
         end else if (INT && ie_q && !stk_full) begin
            stk_push = 1'b1;
            pc_d     = INT_VEC;
            ie_d     = 1'b0;
            ack_d    = 1'b1;
         end else begin
            pc_d = next_seq;
            if (clrIE) begin
               ie_d = 1'b0;
            end else if (setIE) begin
               ie_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         ie_q    <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ie_q    <= ie_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   assign PC     = pc_q;
   assign IE     = ie_q;
   assign intAck = ack_q;
   assign stkErr = err_q;

endmodule

// File: tb/tb_pc_int_unit.sv
// Scenario tasks plus a randomized run, checked against a queue-based model of
// the PC unit's architectural behaviour.
module tb_pc_int_unit;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst, updPC, isBranch, isRet, setIE, clrIE, INT;
   logic [31:0] brTarget;
   logic [31:0] PC, NPC;
   logic        intAck, IE, stkErr;
   logic [1:0]  stkDepth;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   logic [31:0] m_pc;
   logic        m_ie, m_ack, m_err, m_fault;
   logic [31:0] m_stk[$];

   always #5 clk = ~clk;

   pc_int_unit #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .updPC(updPC), .isBranch(isBranch), .brTarget(brTarget),
      .isRet(isRet), .setIE(setIE), .clrIE(clrIE), .INT(INT),
      .PC(PC), .NPC(NPC), .intAck(intAck), .IE(IE), .stkDepth(stkDepth), .stkErr(stkErr)
   );

   task automatic model_step(input logic r, u, b, input logic [31:0] t,
                             input logic re, s, c, i);
      logic [31:0] npc, seq;
      m_ack = 1'b0;
      if (r) begin
         m_pc = 32'h0; m_ie = 1'b0; m_err = 1'b0; m_fault = 1'b0;
         m_stk.delete();
      end else if (!m_fault && u) begin
         npc = m_pc + 32'd4;
         seq = b ? t : npc;
         if (re && m_stk.size() == 0) begin
            m_pc = npc; m_err = 1'b1; m_fault = 1'b1;
         end else if (re) begin
            m_pc = m_stk.pop_back(); m_ie = 1'b1;
         end else if (i && m_ie && m_stk.size() < DEPTH) begin
            m_stk.push_back(seq); m_pc = 32'h100; m_ie = 1'b0; m_ack = 1'b1;
         end else begin
            m_pc = seq;
            if (c) m_ie = 1'b0;
            else if (s) m_ie = 1'b1;
         end
      end
   endtask

   // Apply one cycle of inputs, advance the model, and settle 1 ns past the edge.
   task automatic step(input logic r, u, b, input logic [31:0] t,
                       input logic re, s, c, i);
      rst = r; updPC = u; isBranch = b; brTarget = t;
      isRet = re; setIE = s; clrIE = c; INT = i;
      @(posedge clk);
      model_step(r, u, b, t, re, s, c, i);
      #1;
      $display("txn rst=%b upd=%b br=%b tgt=%h ret=%b sie=%b cie=%b int=%b -> PC=%h IE=%b dep=%0d ack=%b err=%b",
               r, u, b, t, re, s, c, i, PC, IE, stkDepth, intAck, stkErr);
   endtask

   task automatic test_reset();
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (PC !== 32'h0 || IE !== 1'b0 || stkDepth !== 2'd0 || intAck !== 1'b0 || stkErr !== 1'b0) begin
         miscompares++;
         $display("FAIL reset actual PC=%h IE=%b dep=%0d ack=%b err=%b required 0/0/0/0/0",
                  PC, IE, stkDepth, intAck, stkErr);
      end
      vectors++;
      if (NPC !== 32'h4) begin
         miscompares++;
         $display("FAIL reset_npc actual=%h required=%h", NPC, 32'h4);
      end
   endtask

   task automatic test_sequential();
      for (int k = 1; k <= 3; k++) begin
         step(0, 1, 0, 0, 0, 0, 0, 0);
         vectors++;
         if (PC !== 32'(4 * k) || NPC !== 32'(4 * k + 4) || IE !== 1'b0 || stkDepth !== 2'd0) begin
            miscompares++;
            $display("FAIL seq_%0d actual PC=%h NPC=%h IE=%b dep=%0d required PC=%h NPC=%h IE=0 dep=0",
                     k, PC, NPC, IE, stkDepth, 32'(4 * k), 32'(4 * k + 4));
         end
      end
   endtask

   task automatic test_branch();
      step(0, 1, 1, 32'h20, 0, 0, 0, 0);
      step(0, 0, 1, 32'h80, 0, 0, 0, 0);
      vectors++;
      if (PC !== 32'h20) begin
         miscompares++;
         $display("FAIL branch_hold actual=%h required=%h", PC, 32'h20);
      end
      step(0, 1, 1, 32'h80, 0, 0, 0, 0);
      vectors++;
      if (PC !== 32'h80) begin
         miscompares++;
         $display("FAIL branch_take actual=%h required=%h", PC, 32'h80);
      end
   endtask

   task automatic test_interrupt();
      step(0, 1, 1, 32'h40, 0, 1, 0, 0);
      vectors++;
      if (PC !== 32'h40 || IE !== 1'b1) begin
         miscompares++;
         $display("FAIL int_setup actual PC=%h IE=%b required PC=40 IE=1", PC, IE);
      end
      step(0, 0, 0, 0, 0, 0, 0, 1);
      vectors++;
      if (PC !== 32'h40 || intAck !== 1'b0) begin
         miscompares++;
         $display("FAIL int_no_upd actual PC=%h ack=%b required PC=40 ack=0", PC, intAck);
      end
      step(0, 1, 0, 0, 0, 0, 0, 1);
      vectors++;
      if (PC !== 32'h100 || IE !== 1'b0 || stkDepth !== 2'd1 || intAck !== 1'b1) begin
         miscompares++;
         $display("FAIL int_entry actual PC=%h IE=%b dep=%0d ack=%b required PC=100 IE=0 dep=1 ack=1",
                  PC, IE, stkDepth, intAck);
      end
      step(0, 0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (intAck !== 1'b0) begin
         miscompares++;
         $display("FAIL int_ack_pulse actual=%b required=0", intAck);
      end
      step(0, 1, 0, 0, 1, 0, 0, 0);
      vectors++;
      if (PC !== 32'h44 || IE !== 1'b1 || stkDepth !== 2'd0) begin
         miscompares++;
         $display("FAIL reti actual PC=%h IE=%b dep=%0d required PC=44 IE=1 dep=0", PC, IE, stkDepth);
      end
   endtask

   task automatic test_branch_int();
      step(0, 1, 1, 32'h200, 0, 1, 0, 1);
      vectors++;
      if (PC !== 32'h100 || stkDepth !== 2'd1 || IE !== 1'b0) begin
         miscompares++;
         $display("FAIL brint_entry actual PC=%h dep=%0d IE=%b required PC=100 dep=1 IE=0", PC, stkDepth, IE);
      end
      step(0, 1, 0, 0, 1, 0, 0, 0);
      vectors++;
      if (PC !== 32'h200) begin
         miscompares++;
         $display("FAIL brint_return actual=%h required=%h", PC, 32'h200);
      end
   endtask

   task automatic test_nesting();
      step(0, 1, 0, 0, 0, 0, 0, 1);   // 0x200 -> ISR, pushes 0x204
      step(0, 1, 0, 0, 0, 1, 0, 0);   // setIE, PC 0x104
      step(0, 1, 0, 0, 0, 0, 0, 1);   // nested, pushes 0x108
      vectors++;
      if (stkDepth !== 2'd2 || PC !== 32'h100 || intAck !== 1'b1) begin
         miscompares++;
         $display("FAIL nest_depth2 actual dep=%0d PC=%h ack=%b required dep=2 PC=100 ack=1", stkDepth, PC, intAck);
      end
      step(0, 1, 0, 0, 0, 1, 0, 0);   // setIE, PC 0x104
      step(0, 1, 0, 0, 0, 0, 0, 1);   // full: not accepted
      vectors++;
      if (stkDepth !== 2'd2 || PC !== 32'h108 || intAck !== 1'b0 || IE !== 1'b1) begin
         miscompares++;
         $display("FAIL nest_full actual dep=%0d PC=%h ack=%b IE=%b required dep=2 PC=108 ack=0 IE=1",
                  stkDepth, PC, intAck, IE);
      end
      step(0, 1, 0, 0, 1, 0, 0, 1);   // RETI with INT pending
      vectors++;
      if (PC !== 32'h108 || stkDepth !== 2'd1 || intAck !== 1'b0 || IE !== 1'b1) begin
         miscompares++;
         $display("FAIL nest_reti actual PC=%h dep=%0d ack=%b IE=%b required PC=108 dep=1 ack=0 IE=1",
                  PC, stkDepth, intAck, IE);
      end
      step(0, 1, 0, 0, 0, 0, 0, 1);   // pending INT now taken, pushes 0x10c
      vectors++;
      if (PC !== 32'h100 || stkDepth !== 2'd2 || intAck !== 1'b1) begin
         miscompares++;
         $display("FAIL nest_pending actual PC=%h dep=%0d ack=%b required PC=100 dep=2 ack=1", PC, stkDepth, intAck);
      end
      step(0, 1, 0, 0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 1, 0, 0, 0);
      vectors++;
      if (PC !== 32'h204 || stkDepth !== 2'd0) begin
         miscompares++;
         $display("FAIL nest_unwind actual PC=%h dep=%0d required PC=204 dep=0", PC, stkDepth);
      end
   endtask

   task automatic test_fault();
      step(0, 1, 0, 0, 1, 0, 0, 0);
      vectors++;
      if (stkErr !== 1'b1 || PC !== 32'h208) begin
         miscompares++;
         $display("FAIL fault_entry actual err=%b PC=%h required err=1 PC=208", stkErr, PC);
      end
      step(0, 1, 1, 32'h300, 0, 1, 0, 1);
      step(0, 1, 0, 0, 0, 0, 0, 1);
      vectors++;
      if (PC !== 32'h208 || intAck !== 1'b0 || stkDepth !== 2'd0 || stkErr !== 1'b1) begin
         miscompares++;
         $display("FAIL fault_frozen actual PC=%h ack=%b dep=%0d err=%b required PC=208 ack=0 dep=0 err=1",
                  PC, intAck, stkDepth, stkErr);
      end
      step(1, 0, 0, 0, 0, 0, 0, 0);
      vectors++;
      if (PC !== 32'h0 || stkErr !== 1'b0) begin
         miscompares++;
         $display("FAIL fault_reset actual PC=%h err=%b required PC=0 err=0", PC, stkErr);
      end
   endtask

   task automatic test_random();
      logic r, u, b, re, s, c, i;
      logic [31:0] t;
      for (int n = 0; n < 400; n++) begin
         r  = ($urandom_range(0, 39) == 0);
         u  = ($urandom_range(0, 3) != 0);
         b  = ($urandom_range(0, 3) == 0);
         t  = {$urandom_range(0, 32'h3fff), 2'b00};
         re = ($urandom_range(0, 6) == 0);
         s  = ($urandom_range(0, 2) == 0);
         c  = ($urandom_range(0, 5) == 0);
         i  = ($urandom_range(0, 2) == 0);
         step(r, u, b, t, re, s, c, i);
         vectors++;
         if (PC !== m_pc || NPC !== m_pc + 32'd4 || IE !== m_ie || stkDepth !== 2'(m_stk.size())
             || intAck !== m_ack || stkErr !== m_err) begin
            miscompares++;
            $display("FAIL random_%0d actual PC=%h NPC=%h IE=%b dep=%0d ack=%b err=%b required PC=%h NPC=%h IE=%b dep=%0d ack=%b err=%b",
                     n, PC, NPC, IE, stkDepth, intAck, stkErr,
                     m_pc, m_pc + 32'd4, m_ie, m_stk.size(), m_ack, m_err);
         end
      end
   endtask

   initial begin
      rst = 1'b1; updPC = 1'b0; isBranch = 1'b0; brTarget = '0;
      isRet = 1'b0; setIE = 1'b0; clrIE = 1'b0; INT = 1'b0;
      m_pc = '0; m_ie = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_fault = 1'b0;
      test_reset();
      test_sequential();
      test_branch();
      test_interrupt();
      test_branch_int();
      test_nesting();
      test_fault();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
